// File: rtl/trace_pkg.sv
// Shared types and constants for the commit-trace recorder.
package trace_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned RADDR_W     = 5;
    localparam int unsigned FLAGS_W     = 7;
    localparam int unsigned TRACE_REC_W = 103;

    // Bit offsets of each field inside a packed trace record
    localparam int unsigned REC_ADDR3_LSB = 0;
    localparam int unsigned REC_MEMW_BIT  = 5;
    localparam int unsigned REC_REGW_BIT  = 6;
    localparam int unsigned REC_ALU_LSB   = 7;
    localparam int unsigned REC_INST_LSB  = 39;
    localparam int unsigned REC_PC_LSB    = 71;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    inst;
        logic [XLEN-1:0]    alu;
        logic               reg_write;
        logic               mem_write;
        logic [RADDR_W-1:0] reg_addr3;
    } trace_rec_t;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace buffer: one write port, one registered read port, read-before-write.
module trace_ram
    import trace_pkg::*;
#(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  trace_rec_t        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output trace_rec_t        rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    trace_rec_t mem [DEPTH];

    // Non-blocking read and write on the same edge gives old data on a colliding read
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/trace_capture.sv
// Commit-trace recorder: circular capture around a PC-match trigger, frozen window
// exposed on a registered read port.
module trace_capture
    import trace_pkg::*;
#(
    parameter int unsigned     DEPTH_LOG2 = 4,
    parameter logic [XLEN-1:0] TRIG_PC    = 32'h0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    EN,
    input  logic [XLEN-1:0]         PC,
    input  logic [XLEN-1:0]         INST_DATA,
    input  logic [XLEN-1:0]         ALU_RES,
    input  logic                    REG_WRITE,
    input  logic                    MEM_WRITE,
    input  logic [RADDR_W-1:0]      REG_ADDR3,
    input  logic                    ARM,
    input  logic [DEPTH_LOG2-1:0]   POST_COUNT,
    input  logic [DEPTH_LOG2-1:0]   RD_IDX,
    output logic [XLEN-1:0]         RD_PC,
    output logic [XLEN-1:0]         RD_INST,
    output logic [XLEN-1:0]         RD_ALU,
    output logic [FLAGS_W-1:0]      RD_FLAGS,
    output logic                    RD_VALID,
    output logic [DEPTH_LOG2:0]     FILL,
    output logic [DEPTH_LOG2-1:0]   TRIG_IDX,
    output logic                    BUSY,
    output logic                    DONE
);

    localparam int unsigned AW    = DEPTH_LOG2;
    localparam int unsigned FW    = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    trace_state_e  state, state_nxt;
    logic [AW-1:0] wr_ptr, wr_ptr_nxt;
    logic [FW-1:0] fill, fill_nxt;
    logic [AW-1:0] trig_slot, trig_slot_nxt;
    logic [AW-1:0] post_cnt, post_cnt_nxt;
    logic [AW-1:0] trig_idx_nxt;
    logic [AW-1:0] rd_slot;
    logic          we;
    logic          rd_valid_q;
    trace_rec_t    wr_rec;
    trace_rec_t    rd_rec;

    // Next-state and capture bookkeeping
    always_comb begin
        state_nxt     = state;
        wr_ptr_nxt    = wr_ptr;
        fill_nxt      = fill;
        trig_slot_nxt = trig_slot;
        post_cnt_nxt  = post_cnt;
        we            = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (ARM) begin
                    wr_ptr_nxt    = '0;
                    fill_nxt      = '0;
                    trig_slot_nxt = '0;
                    state_nxt     = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (EN) begin
                    we = 1'b1;
                    if (PC == TRIG_PC) begin
                        trig_slot_nxt = wr_ptr;
                        if (POST_COUNT == '0) begin
                            state_nxt = ST_DONE;
                        end else begin
                            post_cnt_nxt = POST_COUNT;
                            state_nxt    = ST_POST;
                        end
                    end
                end
            end
            ST_POST: begin
                if (EN) begin
                    we           = 1'b1;
                    post_cnt_nxt = AW'(post_cnt - AW'(1));
                    if (post_cnt == AW'(1)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (we) begin
            wr_ptr_nxt = AW'(wr_ptr + AW'(1));
            if (fill != FW'(DEPTH)) begin
                fill_nxt = FW'(fill + FW'(1));
            end
        end
        trig_idx_nxt = AW'(trig_slot_nxt - AW'(wr_ptr_nxt - fill_nxt[AW-1:0]));
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr     <= '0;
            fill       <= '0;
            trig_slot  <= '0;
            post_cnt   <= '0;
            FILL       <= '0;
            TRIG_IDX   <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            fill       <= fill_nxt;
            trig_slot  <= trig_slot_nxt;
            post_cnt   <= post_cnt_nxt;
            FILL       <= fill_nxt;
            TRIG_IDX   <= trig_idx_nxt;
            BUSY       <= (state_nxt == ST_ARMED) || (state_nxt == ST_POST);
            DONE       <= (state_nxt == ST_DONE);
            rd_valid_q <= ({1'b0, RD_IDX} < fill);
        end
    end

    // Logical index 0 is the oldest retained entry
    assign rd_slot = AW'(AW'(wr_ptr - fill[AW-1:0]) + RD_IDX);

    assign wr_rec = '{pc: PC, inst: INST_DATA, alu: ALU_RES, reg_write: REG_WRITE,
                      mem_write: MEM_WRITE, reg_addr3: REG_ADDR3};

    trace_ram #(.ADDR_W(AW)) u_ram (
        .clk   (CLK),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (wr_rec),
        .raddr (rd_slot),
        .rdata (rd_rec)
    );

    // RAM data is uninitialised, so gate it with the registered valid bit
    assign RD_VALID = rd_valid_q;
    assign RD_PC    = rd_valid_q ? rd_rec.pc   : '0;
    assign RD_INST  = rd_valid_q ? rd_rec.inst : '0;
    assign RD_ALU   = rd_valid_q ? rd_rec.alu  : '0;
    assign RD_FLAGS = rd_valid_q ? {rd_rec.reg_write, rd_rec.mem_write, rd_rec.reg_addr3} : '0;

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture with DEPTH=16 and trigger PC 0x40.
module tb_trace_capture;

    logic        CLK, RST, EN, REG_WRITE, MEM_WRITE, ARM;
    logic [31:0] PC, INST_DATA, ALU_RES;
    logic [4:0]  REG_ADDR3;
    logic [3:0]  POST_COUNT, RD_IDX, TRIG_IDX;
    logic [31:0] RD_PC, RD_INST, RD_ALU;
    logic [6:0]  RD_FLAGS;
    logic        RD_VALID, BUSY, DONE;
    logic [4:0]  FILL;

    int n_assert = 0;
    int n_fail   = 0;
    int samples;

    trace_capture #(.DEPTH_LOG2(4), .TRIG_PC(32'h40)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .PC(PC), .INST_DATA(INST_DATA), .ALU_RES(ALU_RES),
        .REG_WRITE(REG_WRITE), .MEM_WRITE(MEM_WRITE), .REG_ADDR3(REG_ADDR3), .ARM(ARM),
        .POST_COUNT(POST_COUNT), .RD_IDX(RD_IDX), .RD_PC(RD_PC), .RD_INST(RD_INST),
        .RD_ALU(RD_ALU), .RD_FLAGS(RD_FLAGS), .RD_VALID(RD_VALID), .FILL(FILL),
        .TRIG_IDX(TRIG_IDX), .BUSY(BUSY), .DONE(DONE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Debug-bus payload derived from the PC so every field is predictable
    task automatic drive(input logic [31:0] pc, input logic en);
        PC        = pc;
        INST_DATA = ~pc;
        ALU_RES   = pc + 32'd1;
        REG_WRITE = pc[2];
        MEM_WRITE = pc[3];
        REG_ADDR3 = pc[8:4];
        EN        = en;
    endtask

    task automatic rd(input logic [3:0] idx);
        RD_IDX = idx;
        cyc();
    endtask

    task automatic arm_pulse(input logic [3:0] post);
        POST_COUNT = post;
        ARM        = 1'b1;
        EN         = 1'b0;
        cyc();
        ARM        = 1'b0;
    endtask

    initial begin
        RST = 1'b0; ARM = 1'b0; POST_COUNT = '0; RD_IDX = '0;
        drive(32'h0, 1'b0);
        #2;
        chk("reset_fill", 32'(FILL), 32'd0);
        chk("reset_busy", 32'(BUSY), 32'd0);
        chk("reset_done", 32'(DONE), 32'd0);
        chk("reset_trig_idx", 32'(TRIG_IDX), 32'd0);
        chk("reset_rd_pc", RD_PC, 32'd0);
        #10 RST = 1'b1;

        // 1: no ARM, EN high -> nothing recorded
        for (int i = 0; i < 20; i++) begin
            drive(32'(i * 4), 1'b1);
            cyc();
        end
        drive(32'h0, 1'b0);
        chk("t1_fill", 32'(FILL), 32'd0);
        chk("t1_done", 32'(DONE), 32'd0);
        rd(4'd5);
        chk("t1_rd_valid", 32'(RD_VALID), 32'd0);
        chk("t1_rd_pc", RD_PC, 32'd0);

        // 2: wraparound capture with 3 post-trigger entries
        arm_pulse(4'd3);
        chk("t2_busy_armed", 32'(BUSY), 32'd1);
        samples = 0;
        for (int i = 0; i < 40; i++) begin
            drive(32'(i * 4), 1'b1);
            cyc();
            samples++;
            if (DONE) break;
        end
        drive(32'h0, 1'b0);
        chk("t2_samples", 32'(samples), 32'd20);
        chk("t2_done", 32'(DONE), 32'd1);
        chk("t2_busy", 32'(BUSY), 32'd0);
        chk("t2_fill", 32'(FILL), 32'd16);
        chk("t2_trig_idx", 32'(TRIG_IDX), 32'd12);
        rd(4'd0);
        chk("t2_rd0_valid", 32'(RD_VALID), 32'd1);
        chk("t2_rd0_pc", RD_PC, 32'h10);
        chk("t2_rd0_inst", RD_INST, 32'hFFFF_FFEF);
        chk("t2_rd0_alu", RD_ALU, 32'h11);
        chk("t2_rd0_flags", 32'(RD_FLAGS), 32'h01);
        rd(4'd12);
        chk("t2_rd12_pc", RD_PC, 32'h40);
        rd(4'd15);
        chk("t2_rd15_pc", RD_PC, 32'h4C);
        chk("t2_rd15_flags", 32'(RD_FLAGS), 32'h64);

        // 3: trigger on the third sample, no post entries
        arm_pulse(4'd0);
        drive(32'h38, 1'b1); cyc();
        drive(32'h3C, 1'b1); cyc();
        chk("t3_not_done", 32'(DONE), 32'd0);
        drive(32'h40, 1'b1); cyc();
        drive(32'h0, 1'b0);
        chk("t3_done", 32'(DONE), 32'd1);
        chk("t3_fill", 32'(FILL), 32'd3);
        chk("t3_trig_idx", 32'(TRIG_IDX), 32'd2);
        rd(4'd3);
        chk("t3_rd3_valid", 32'(RD_VALID), 32'd0);
        chk("t3_rd3_pc", RD_PC, 32'd0);
        rd(4'd2);
        chk("t3_rd2_pc", RD_PC, 32'h40);

        // 4: EN gaps during POST
        arm_pulse(4'd2);
        drive(32'h40, 1'b1); cyc();
        drive(32'h44, 1'b1); cyc();
        chk("t4_busy_mid", 32'(BUSY), 32'd1);
        drive(32'h99, 1'b0); cyc();
        chk("t4_fill_gap", 32'(FILL), 32'd2);
        drive(32'h4C, 1'b1); cyc();
        chk("t4_done", 32'(DONE), 32'd1);
        drive(32'h50, 1'b0); cyc();
        chk("t4_fill", 32'(FILL), 32'd3);
        chk("t4_trig_idx", 32'(TRIG_IDX), 32'd0);
        rd(4'd1);
        chk("t4_rd1_pc", RD_PC, 32'h44);
        rd(4'd2);
        chk("t4_rd2_pc", RD_PC, 32'h4C);

        // 5: ARM beats a coincident trigger sample in DONE
        ARM = 1'b1; POST_COUNT = 4'd0;
        drive(32'h40, 1'b1); cyc();
        ARM = 1'b0;
        drive(32'h08, 1'b0);
        chk("t5_busy", 32'(BUSY), 32'd1);
        chk("t5_done", 32'(DONE), 32'd0);
        chk("t5_fill", 32'(FILL), 32'd0);
        drive(32'h08, 1'b1); cyc();
        drive(32'h0, 1'b0);
        chk("t5_fill_after", 32'(FILL), 32'd1);
        chk("t5_still_armed", 32'(DONE), 32'd0);
        rd(4'd0);
        chk("t5_rd0_pc", RD_PC, 32'h08);

        // 6: asynchronous reset in the middle of POST
        drive(32'h40, 1'b1); POST_COUNT = 4'd5; cyc();
        drive(32'h44, 1'b1); cyc();
        drive(32'h0, 1'b0);
        chk("t6_busy_pre", 32'(BUSY), 32'd1);
        #3 RST = 1'b0;
        #1;
        chk("t6_rst_fill", 32'(FILL), 32'd0);
        chk("t6_rst_busy", 32'(BUSY), 32'd0);
        chk("t6_rst_done", 32'(DONE), 32'd0);
        chk("t6_rst_valid", 32'(RD_VALID), 32'd0);
        chk("t6_rst_rd_pc", RD_PC, 32'd0);
        #7 RST = 1'b1;
        cyc();
        chk("t6_idle_fill", 32'(FILL), 32'd0);
        arm_pulse(4'd1);
        drive(32'h20, 1'b1); cyc();
        drive(32'h0, 1'b0);
        chk("t6_restart_fill", 32'(FILL), 32'd1);
        rd(4'd0);
        chk("t6_restart_pc", RD_PC, 32'h20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
